// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_regfile
// Description : Oversampled I2C target fronting a byte-wide register bank.
//               Writes: addr+W, pointer byte, N data bytes.
//               Reads : addr+R (plain or after repeated START), N bytes.
//               The register pointer auto-increments after every byte.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  parameter int         PTR_W      = $clog2(DEPTH),
  parameter bit         WRAP       = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  input  logic [7:0]       reg_rdata,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_PTR     = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RD_LOAD = 3'd4,
    ST_READ    = 3'd5
  } state_t;

  // Pin synchronisers and previous-value registers for edge detection
  logic [1:0]       scl_sync_q;
  logic [1:0]       sda_sync_q;
  logic             scl_prev_q;
  logic             sda_prev_q;

  // Protocol state
  state_t           state_q;
  logic [3:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             ack_slot_q;   // inside the 9th clock after a byte we acknowledged
  logic [PTR_W-1:0] ptr_q;
  logic             sda_oe_q;
  logic [7:0]       reg_wdata_q;
  logic             reg_we_q;
  logic             busy_q;

  // Derived combinational signals
  logic             scl_s;
  logic             sda_s;
  logic             scl_rise;
  logic             scl_fall;
  logic             start_det;
  logic             stop_det;
  logic             addr_hit;
  logic             ptr_ok;
  logic [PTR_W-1:0] ptr_inc_d;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev_q & sda_s;
  assign addr_hit  = (shift_q[7:1] == SLAVE_ADDR);
  assign ptr_ok    = ({1'b0, shift_q} < 9'(DEPTH));

  // Next pointer value: wrap to 0 or saturate at the last register
  always_comb begin
    ptr_inc_d = ptr_q + 1'b1;
    if (ptr_q == PTR_W'(DEPTH - 1)) begin
      ptr_inc_d = WRAP ? '0 : ptr_q;
    end
  end

  // Double-flop the asynchronous pads; bus idles high so reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // Protocol FSM: bit shifting, ACK drive, register strobes and pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ack_slot_q  <= 1'b0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      reg_we_q <= 1'b0;
      // The pointer steps the clk after the strobe so reg_addr is stable while reg_we=1
      if (reg_we_q) begin
        ptr_q <= ptr_inc_d;
      end

      if (stop_det) begin
        state_q    <= ST_IDLE;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
        ack_slot_q <= 1'b0;
      end else if (start_det) begin
        // Also a repeated START: any byte in flight is dropped without a strobe
        state_q    <= ST_ADDR;
        bit_cnt_q  <= 4'd0;
        ack_slot_q <= 1'b0;
        sda_oe_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            sda_oe_q <= 1'b0;
          end

          ST_ADDR, ST_PTR, ST_WRITE: begin
            if (ack_slot_q) begin
              if (scl_fall) begin
                sda_oe_q   <= 1'b0;
                ack_slot_q <= 1'b0;
                bit_cnt_q  <= 4'd0;
              end
            end else if (scl_rise && (bit_cnt_q != 4'd8)) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
              case (state_q)
                ST_ADDR: begin
                  if (addr_hit) begin
                    sda_oe_q   <= 1'b1;
                    ack_slot_q <= 1'b1;
                    busy_q     <= 1'b1;
                    state_q    <= shift_q[0] ? ST_RD_LOAD : ST_PTR;
                  end else begin
                    state_q <= ST_IDLE;
                  end
                end
                ST_PTR: begin
                  if (ptr_ok) begin
                    ptr_q      <= shift_q[PTR_W-1:0];
                    sda_oe_q   <= 1'b1;
                    ack_slot_q <= 1'b1;
                    state_q    <= ST_WRITE;
                  end else begin
                    // Out-of-range pointer: refuse and drop the transfer
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                  end
                end
                default: begin
                  reg_wdata_q <= shift_q;
                  reg_we_q    <= 1'b1;
                  sda_oe_q    <= 1'b1;
                  ack_slot_q  <= 1'b1;
                end
              endcase
            end
          end

          ST_RD_LOAD: begin
            // The fall that closes the ACK slot launches bit 7 of the new byte
            if (scl_fall) begin
              shift_q    <= reg_rdata;
              sda_oe_q   <= ~reg_rdata[7];
              bit_cnt_q  <= 4'd1;
              ack_slot_q <= 1'b0;
              state_q    <= ST_READ;
            end
          end

          ST_READ: begin
            if (scl_fall) begin
              if (bit_cnt_q < 4'd8) begin
                sda_oe_q  <= ~shift_q[6];
                shift_q   <= {shift_q[6:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end else if (bit_cnt_q == 4'd8) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd9;
              end
            end else if (scl_rise && (bit_cnt_q == 4'd9)) begin
              if (!sda_s) begin
                ptr_q   <= ptr_inc_d;
                state_q <= ST_RD_LOAD;
              end else begin
                // Master NACK: stay off the bus, busy remains until STOP
                state_q <= ST_IDLE;
              end
            end
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = ptr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_regfile
// Description : Bit-banged I2C master driving two targets on one bus
//               (0x50 wrapping, 0x3C saturating) against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regfile;

  localparam int         Q      = 4;
  localparam logic [6:0] ADDR_A = 7'h50;
  localparam logic [6:0] ADDR_B = 7'h3C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       csr_init = 1'b1;
  logic       sda_line;
  logic       sda_oe_a, sda_oe_b, we_a, we_b, busy_a, busy_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b, rdata_a, rdata_b;
  logic [7:0] csr_a [16];
  logic [7:0] csr_b [16];

  // Transaction model
  int         tgt = -1;
  logic [3:0] m_ptr [2];
  logic [7:0] mdl [2][16];
  bit         sel [2];
  bit         m_busy [2];
  logic [11:0] q_a [$];
  logic [11:0] q_b [$];
  logic [11:0] cmp_e;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign sda_line = m_sda & ~sda_oe_a & ~sda_oe_b;
  assign rdata_a  = csr_a[addr_a];
  assign rdata_b  = csr_b[addr_b];

  i2c_slave_regfile #(.SLAVE_ADDR(ADDR_A), .DEPTH(16), .WRAP(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .scl_i(m_scl), .sda_i(sda_line), .sda_oe(sda_oe_a),
    .reg_addr(addr_a), .reg_wdata(wdata_a), .reg_we(we_a), .reg_rdata(rdata_a), .busy(busy_a)
  );

  i2c_slave_regfile #(.SLAVE_ADDR(ADDR_B), .DEPTH(16), .WRAP(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .scl_i(m_scl), .sda_i(sda_line), .sda_oe(sda_oe_b),
    .reg_addr(addr_b), .reg_wdata(wdata_b), .reg_we(we_b), .reg_rdata(rdata_b), .busy(busy_b)
  );

  function automatic logic [7:0] init_a(input int i);
    if (i == 5) return 8'h11;
    if (i == 6) return 8'h22;
    return 8'(i * 3 + 1);
  endfunction

  function automatic logic [7:0] init_b(input int i);
    return 8'(8'hC0 + i);
  endfunction

  function automatic logic [3:0] next_ptr(input logic [3:0] p, input bit wrap);
    int n;
    n = int'(p) + 1;
    if (n >= 16) n = wrap ? 0 : 15;
    return 4'(n);
  endfunction

  // CSR bank behind each target
  always @(posedge clk) begin
    if (csr_init) begin
      for (int i = 0; i < 16; i++) begin
        csr_a[i] <= init_a(i);
        csr_b[i] <= init_b(i);
      end
    end else begin
      if (we_a) csr_a[addr_a] <= wdata_a;
      if (we_b) csr_b[addr_b] <= wdata_b;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per-cycle compare: every write strobe and every SDA pull against the model
  always @(negedge clk) begin
    if (rst_n) begin
      if (we_a) begin
        chk("we_a_expected", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
          cmp_e = q_a.pop_front();
          chk("we_a_addr_data", {20'd0, addr_a, wdata_a}, {20'd0, cmp_e});
        end
      end
      if (we_b) begin
        chk("we_b_expected", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) begin
          cmp_e = q_b.pop_front();
          chk("we_b_addr_data", {20'd0, addr_b, wdata_b}, {20'd0, cmp_e});
        end
      end
      if (sda_oe_a) chk("sda_oe_a_selected", 32'(sel[0]), 32'd1);
      if (sda_oe_b) chk("sda_oe_b_selected", 32'(sel[1]), 32'd1);
    end
  end

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b;  wt(Q);
    m_scl = 1'b1; wt(Q);
    s = sda_line; wt(Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(~mack, s);
  endtask

  task automatic chk_busy();
    chk("busy_a", 32'(busy_a), 32'(m_busy[0]));
    chk("busy_b", 32'(busy_b), 32'(m_busy[1]));
  endtask

  task automatic chk_ptr(input int k);
    chk(k == 0 ? "reg_addr_a" : "reg_addr_b", 32'(k == 0 ? addr_a : addr_b), 32'(m_ptr[k]));
  endtask

  task automatic bus_start();
    if (!m_scl) begin
      m_sda = 1'b1; wt(Q);
      m_scl = 1'b1; wt(Q);
    end
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b1; wt(Q);
    m_sda = 1'b1; wt(2 * Q);
    sel[0] = 0; sel[1] = 0; m_busy[0] = 0; m_busy[1] = 0; tgt = -1;
    chk_busy();
  endtask

  task automatic t_addr(input logic [6:0] a, input logic rw);
    logic ack;
    tgt = (a == ADDR_A) ? 0 : (a == ADDR_B) ? 1 : -1;
    sel[0] = (tgt == 0);
    sel[1] = (tgt == 1);
    wr_byte({a, rw}, ack);
    chk("addr_ack", 32'(ack), 32'(tgt >= 0));
    if (tgt >= 0) m_busy[tgt] = 1;
    chk_busy();
  endtask

  task automatic t_ptr(input logic [7:0] p);
    logic ack;
    bit   ok;
    ok = (tgt >= 0) && (p < 8'd16);
    wr_byte(p, ack);
    chk("ptr_ack", 32'(ack), 32'(ok));
    if (tgt >= 0) begin
      if (ok) m_ptr[tgt] = p[3:0];
      else begin
        m_busy[tgt] = 0;
        sel[tgt] = 0;
      end
      chk_ptr(tgt);
    end
    chk_busy();
  endtask

  task automatic t_wr(input logic [7:0] d);
    logic ack;
    if (tgt == 0) q_a.push_back({m_ptr[0], d});
    if (tgt == 1) q_b.push_back({m_ptr[1], d});
    if (tgt >= 0) begin
      mdl[tgt][m_ptr[tgt]] = d;
      m_ptr[tgt] = next_ptr(m_ptr[tgt], tgt == 0);
    end
    wr_byte(d, ack);
    chk("data_ack", 32'(ack), 32'(tgt >= 0));
    if (tgt >= 0) chk_ptr(tgt);
  endtask

  task automatic t_rd(input logic mack, output logic [7:0] d);
    logic [7:0] e;
    e = (tgt >= 0) ? mdl[tgt][m_ptr[tgt]] : 8'hFF;
    rd_byte(mack, d);
    chk("rd_data", 32'(d), 32'(e));
    if (tgt >= 0) begin
      if (mack) m_ptr[tgt] = next_ptr(m_ptr[tgt], tgt == 0);
      else sel[tgt] = 0;
      chk_ptr(tgt);
    end
    chk_busy();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d0, d1;
    int n;
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 4'd0; sel[k] = 0; m_busy[k] = 0;
      for (int i = 0; i < 16; i++) mdl[k][i] = (k == 0) ? init_a(i) : init_b(i);
    end
    wt(3);
    csr_init = 1'b0;
    // Reset state
    chk("rst_sda_oe", {31'd0, sda_oe_a | sda_oe_b}, 32'd0);
    chk("rst_busy", {31'd0, busy_a | busy_b}, 32'd0);
    chk("rst_we", {31'd0, we_a | we_b}, 32'd0);
    chk("rst_addr", {24'd0, addr_a, addr_b}, 32'd0);
    rst_n = 1'b1;
    wt(5);

    // T1: write AA, BB from pointer 3
    bus_start(); t_addr(ADDR_A, 1'b0); t_ptr(8'h03); t_wr(8'hAA); t_wr(8'hBB); bus_stop();
    chk("t1_csr3", 32'(csr_a[3]), 32'h0AA);
    chk("t1_csr4", 32'(csr_a[4]), 32'h0BB);
    chk("t1_busy_after_stop", 32'(busy_a), 32'd0);

    // T2: pointer 5, repeated START, read two bytes
    bus_start(); t_addr(ADDR_A, 1'b0); t_ptr(8'h05);
    bus_start(); t_addr(ADDR_A, 1'b1); t_rd(1'b1, d0); t_rd(1'b0, d1); bus_stop();
    chk("t2_byte0", 32'(d0), 32'h11);
    chk("t2_byte1", 32'(d1), 32'h22);
    chk("t2_reg_addr", 32'(addr_a), 32'd6);

    // T3: address 0x51 matches nobody
    bus_start(); t_addr(7'h51, 1'b0); t_ptr(8'h00); bus_stop();
    chk("t3_busy", 32'(busy_a), 32'd0);

    // T4: wrap on target A, saturate on target B
    bus_start(); t_addr(ADDR_A, 1'b0); t_ptr(8'h0F); t_wr(8'h77); t_wr(8'h88); bus_stop();
    chk("t4_wrap_csr15", 32'(csr_a[15]), 32'h77);
    chk("t4_wrap_csr0", 32'(csr_a[0]), 32'h88);
    bus_start(); t_addr(ADDR_B, 1'b0); t_ptr(8'h0F); t_wr(8'h99); t_wr(8'h9A); bus_stop();
    chk("t4_sat_csr15", 32'(csr_b[15]), 32'h9A);
    chk("t4_sat_addr", 32'(addr_b), 32'd15);

    // T5: out-of-range pointer refused, old pointer kept
    bus_start(); t_addr(ADDR_A, 1'b0); t_ptr(8'h10); bus_stop();
    chk("t5_ptr_kept", 32'(addr_a), 32'd1);
    bus_start(); t_addr(ADDR_A, 1'b1); t_rd(1'b0, d0); bus_stop();
    chk("t5_read_old_ptr", 32'(d0), 32'h04);

    // T6: asynchronous reset while the target drives SDA
    bus_start(); t_addr(ADDR_A, 1'b1);
    n = 0;
    while (!sda_oe_a && n < 40) begin
      wt(1);
      n++;
    end
    chk("t6_oe_before_reset", 32'(sda_oe_a), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("t6_oe_async_clear", 32'(sda_oe_a), 32'd0);
    chk("t6_ptr_reset", 32'(addr_a), 32'd0);
    m_scl = 1'b1; m_sda = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 4'd0; sel[k] = 0; m_busy[k] = 0;
    end
    tgt = -1;
    wt(4);
    rst_n = 1'b1;
    wt(4);
    bus_start(); t_addr(ADDR_A, 1'b0); t_ptr(8'h02); t_wr(8'h5A); bus_stop();
    bus_start(); t_addr(ADDR_A, 1'b0); t_ptr(8'h02);
    bus_start(); t_addr(ADDR_A, 1'b1); t_rd(1'b0, d0); bus_stop();
    chk("t6_readback", 32'(d0), 32'h5A);

    wt(10);
    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
